// File: rtl/ca_rollback.sv
// Reversible cellular-automaton rollback engine.
// Undoes N forward shift-and-feedback steps, one backward step per clock.
module ca_rollback #(
  parameter int WIDTH = 32,
  parameter int TAP_B = 12,
  parameter int TAP_C = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_state,
  input  logic [2:0]       in_rule,
  input  logic [15:0]      in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_state,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           st_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic [2:0]       rule_q;
  logic [15:0]      cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  function automatic logic h_fn(
    input logic [2:0] r,
    input logic       b,
    input logic       c
  );
    logic v;
    v = 1'b0;
    case (r)
      3'd1:    v = b | c;
      3'd2:    v = b;
      3'd3:    v = c;
      3'd4:    v = b & c;
      3'd5:    v = b ^ c;
      3'd6:    v = b & ~c;
      3'd7:    v = c & ~b;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Inverse of the forward step: the taps sit one bit higher
  // because the forward step shifted them left by one.
  always_comb begin
    s_d = '0;
    s_d[WIDTH-2:0] = s_q[WIDTH-1:1];
    s_d[WIDTH-1] = s_q[0] ^ h_fn(rule_q, s_q[TAP_B+1], s_q[TAP_C+1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      s_q         <= '0;
      rule_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid) begin
            s_q        <= in_state;
            rule_q     <= in_rule;
            cnt_q      <= in_count;
            in_ready_q <= 1'b0;
            if (in_count != 16'd0) begin
              st_q   <= RUN;
              busy_q <= 1'b1;
            end else begin
              st_q        <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          s_q   <= s_d;
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            st_q        <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          st_q        <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = s_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ca_rollback.sv
// Scoreboard bench for ca_rollback: forward model builds jobs,
// expected pre-images queue up and are checked as results appear.
module tb_ca_rollback;

  localparam int W  = 32;
  localparam int TB = 12;
  localparam int TC = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_state;
  logic [2:0]   in_rule;
  logic [15:0]  in_count;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ca_rollback #(.WIDTH(W), .TAP_B(TB), .TAP_C(TC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_rule(in_rule), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic hf(input logic [2:0] r, input logic b, input logic c);
    case (r)
      3'd1: return b | c;
      3'd2: return b;
      3'd3: return c;
      3'd4: return b & c;
      3'd5: return b ^ c;
      3'd6: return b & ~c;
      3'd7: return c & ~b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] fwd(input logic [W-1:0] s, input logic [2:0] r);
    return {s[W-2:0], s[W-1] ^ hf(r, s[TB], s[TC])};
  endfunction

  task automatic send_job(input logic [W-1:0] st, input logic [2:0] r,
                          input logic [15:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
    end
    in_valid = 1'b1;
    in_state = st;
    in_rule  = r;
    in_count = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_rule  = ~r;
    in_state = $urandom;
    in_count = 16'($urandom);
  endtask

  task automatic get_result(input int budget, output int lat,
                            output logic [W-1:0] st, output bit got);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < budget);
    got = out_valid;
    st  = out_state;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; in_rule = '0; in_count = '0;
    #3;
    checks++;
    if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (out_state !== 32'h0) begin errors++;
      $display("FAIL reset_out_state: got %h, required 0", out_state); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed(input string nm, input logic [2:0] r,
                            input logic [W-1:0] st, input logic [W-1:0] ex);
    int lat; logic [W-1:0] got_s; bit got; logic [W-1:0] e;
    exp_q.push_back(ex);
    send_job(st, r, 16'd1);
    get_result(10, lat, got_s, got);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++;
      $display("FAIL %s_valid: out_valid got 0, required 1", nm); end
    checks++;
    if (got_s !== e) begin errors++;
      $display("FAIL %s_state: got %h, required %h", nm, got_s, e); end
    checks++;
    if (lat != 2) begin errors++;
      $display("FAIL %s_latency: got %0d, required 2", nm, lat); end
    consume();
  endtask

  task automatic test_rules_random();
    int lat; logic [W-1:0] got_s; bit got; logic [W-1:0] s, t, e;
    for (int r = 1; r <= 7; r++) begin
      s = $urandom;
      t = s;
      for (int k = 0; k < 1000; k++) t = fwd(t, 3'(r));
      exp_q.push_back(s);
      send_job(t, 3'(r), 16'd1000);
      get_result(1100, lat, got_s, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || got_s !== e) begin errors++;
        $display("FAIL rule%0d_state: got %h (valid %b), required %h", r, got_s, got, e); end
      checks++;
      if (lat != 1001) begin errors++;
        $display("FAIL rule%0d_latency: got %0d, required 1001", r, lat); end
      consume();
    end
  endtask

  task automatic test_count0_hold();
    int lat; logic [W-1:0] got_s; bit got; logic [W-1:0] e;
    exp_q.push_back(32'hDEADBEEF);
    send_job(32'hDEADBEEF, 3'd5, 16'd0);
    get_result(10, lat, got_s, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || got_s !== e) begin errors++;
      $display("FAIL count0_state: got %h (valid %b), required %h", got_s, got, e); end
    checks++;
    if (lat != 1) begin errors++;
      $display("FAIL count0_latency: got %0d, required 1", lat); end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL count0_flags: got busy %b in_ready %b, required 0 0", busy, in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_state !== e) begin errors++;
        $display("FAIL hold%0d: got valid %b state %h, required 1 %h", i, out_valid, out_state, e); end
    end
    consume();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL after_consume: got in_ready %b out_valid %b, required 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_midjob();
    int lat; logic [W-1:0] got_s; bit got; logic [W-1:0] s, t, e;
    send_job($urandom, 3'd3, 16'd100);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++;
      $display("FAIL midjob_busy: got %b, required 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midjob_reset: got valid %b ready %b state %h busy %b, required 0 1 0 0",
               out_valid, in_ready, out_state, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
        $display("FAIL post_reset%0d: got valid %b ready %b, required 0 1", i, out_valid, in_ready); end
    end
    s = $urandom;
    t = s;
    for (int k = 0; k < 50; k++) t = fwd(t, 3'd6);
    exp_q.push_back(s);
    send_job(t, 3'd6, 16'd50);
    get_result(100, lat, got_s, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || got_s !== e || lat != 51) begin errors++;
      $display("FAIL post_reset_job: got %h (valid %b lat %0d), required %h lat 51", got_s, got, lat, e); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s1, s2, t1, t2, e;
    int acc1, acc2, nres;
    bit acc, overlap;
    s1 = $urandom; s2 = $urandom;
    t1 = s1; t2 = s2;
    for (int k = 0; k < 3; k++) begin
      t1 = fwd(t1, 3'd4);
      t2 = fwd(t2, 3'd7);
    end
    exp_q.push_back(s1);
    exp_q.push_back(s2);
    acc1 = -1; acc2 = -1; nres = 0; overlap = 0;
    @(negedge clk);
    in_valid = 1'b1; in_state = t1; in_rule = 3'd4; in_count = 16'd3;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      acc = in_valid && in_ready;
      if (in_ready && out_valid) overlap = 1;
      if (out_valid) begin
        e = exp_q.pop_front();
        nres++;
        checks++;
        if (out_state !== e) begin errors++;
          $display("FAIL b2b_state%0d: got %h, required %h", nres, out_state, e); end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (acc1 < 0) begin
          acc1 = cyc; in_state = t2; in_rule = 3'd7;
        end else if (acc2 < 0) begin
          acc2 = cyc; in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (acc2 - acc1 != 5) begin errors++;
      $display("FAIL b2b_interval: got %0d, required 5", acc2 - acc1); end
    checks++;
    if (nres != 2) begin errors++;
      $display("FAIL b2b_results: got %0d, required 2", nres); end
    checks++;
    if (overlap) begin errors++;
      $display("FAIL b2b_overlap: in_ready and out_valid together got 1, required 0"); end
  endtask

  initial begin
    test_reset();
    test_fixed("rule0", 3'd0, 32'h0000_0001, 32'h8000_0000);
    test_fixed("rule2", 3'd2, 32'h0000_2000, 32'h8000_1000);
    test_rules_random();
    test_count0_hold();
    test_reset_midjob();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
